// File: rtl/mips_instr_issue.sv
// Program sequencer feeding MIPS_CPU.Instruction from a small loadable instruction memory.
// Optional ALU result capture is enabled by defining ISSUE_RESULT_CAPTURE_EN.
module mips_instr_issue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              stall,
`ifdef ISSUE_RESULT_CAPTURE_EN
  input  logic [31:0]       ALU_Result,
  output logic [31:0]       result_last,
  output logic [ADDR_W:0]   result_count,
`endif
  output logic [31:0]       Instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [ADDR_W:0]   len_reg;
  logic [31:0]       instr_reg;
  logic              valid_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   len_last;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic              start_ok;
  logic              hold_end;

  assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign len_last    = len_reg - 1'b1;
  assign pc_inc      = pc_reg + 1'b1;
  // Single read port: address 0 when launching, otherwise the next word.
  assign rd_addr     = (state_reg == S_ISSUE) ? pc_inc : '0;
  assign start_ok    = (state_reg == S_IDLE) && start && !load_en;
  assign hold_end    = (state_reg == S_ISSUE) && !stall && (hold_reg == HOLD_LAST);

  // Memory has no reset so a program survives RST_N; writes only land in IDLE.
  always_ff @(posedge CLK) begin
    if ((state_reg == S_IDLE) && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      hold_reg  <= '0;
      len_reg   <= '0;
      instr_reg <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start_ok) begin
            len_reg  <= len_clamped;
            pc_reg   <= '0;
            hold_reg <= '0;
            if (len_clamped == '0) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_ISSUE;
              busy_reg  <= 1'b1;
              valid_reg <= 1'b1;
              instr_reg <= mem[rd_addr];
            end
          end
        end
        S_ISSUE: begin
          if (hold_end) begin
            if ({1'b0, pc_reg} == len_last) begin
              state_reg <= S_DONE;
              busy_reg  <= 1'b0;
              valid_reg <= 1'b0;
              instr_reg <= '0;
              done_reg  <= 1'b1;
            end else begin
              pc_reg    <= pc_inc;
              hold_reg  <= '0;
              instr_reg <= mem[rd_addr];
            end
          end else if (!stall) begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ISSUE_RESULT_CAPTURE_EN
  logic [31:0]     result_last_reg;
  logic [ADDR_W:0] result_count_reg;

  // Capture on the final settled cycle of each word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      result_last_reg  <= '0;
      result_count_reg <= '0;
    end else if (start_ok) begin
      result_last_reg  <= '0;
      result_count_reg <= '0;
    end else if (hold_end) begin
      result_last_reg  <= ALU_Result;
      result_count_reg <= result_count_reg + 1'b1;
    end
  end

  assign result_last  = result_last_reg;
  assign result_count = result_count_reg;
`endif

  assign Instruction = instr_reg;
  assign instr_valid = valid_reg;
  assign pc          = pc_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_mips_instr_issue.sv
// Self-checking bench for mips_instr_issue: randomized runs checked against a cycle-count model.
module tb_mips_instr_issue;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int H      = 2;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [31:0]       load_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   prog_len = '0;
  logic              stall = 1'b0;
  logic [31:0]       Instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;

  int n_compared = 0;
  int n_mismatched = 0;
  logic [31:0] ref_mem [DEPTH];

  always #5 CLK = ~CLK;

  mips_instr_issue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_CYCLES(H)) dut (
    .CLK(CLK), .RST_N(RST_N), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .prog_len(prog_len), .stall(stall),
    .Instruction(Instruction), .instr_valid(instr_valid), .pc(pc),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input bit with_pc);
    check({tag, "_instr"}, Instruction, 32'h0);
    check({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    if (with_pc) check({tag, "_pc"}, {28'h0, pc}, 32'h0);
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    @(negedge CLK);
    load_en = 1'b1;
    load_addr = a[ADDR_W-1:0];
    load_data = d;
    @(negedge CLK);
    load_en = 1'b0;
    ref_mem[a] = d;
    $display("load addr=%0d data=%h", a, d);
  endtask

  // Model: n counts non-stalled issue cycles; the word on show is n/H, and the
  // program ends once n reaches len*H.
  task automatic run_prog(input int plen, input int mode, input bit noise, output int vcyc);
    int L;
    int n;
    int stalls;
    int cyc;
    bit st;
    bit fin;
    L = (plen > DEPTH) ? DEPTH : plen;
    @(negedge CLK);
    start = 1'b1;
    prog_len = plen[ADDR_W:0];
    @(posedge CLK);
    #1;
    start = 1'b0;
    n = 0; stalls = 0; vcyc = 0; cyc = 0; fin = 1'b0;
    while (!fin) begin
      if (n < L * H) begin
        check("valid", {31'h0, instr_valid}, 32'h1);
        check("busy", {31'h0, busy}, 32'h1);
        check("done_early", {31'h0, done}, 32'h0);
        check("instr", Instruction, ref_mem[n / H]);
        check("pc", {28'h0, pc}, n / H);
        vcyc++;
        case (mode)
          1: st = ($urandom_range(0, 3) == 0);
          2: st = (cyc >= 2 && cyc <= 4);
          default: st = 1'b0;
        endcase
        stall = st;
        if (st) stalls++;
        else n++;
        if (noise) begin
          load_en = 1'($urandom_range(0, 1));
          load_addr = ADDR_W'($urandom);
          load_data = $urandom;
          start = 1'($urandom_range(0, 1));
          prog_len = (ADDR_W + 1)'($urandom);
        end
        cyc++;
        @(posedge CLK);
        #1;
      end else begin
        stall = 1'b0;
        load_en = 1'b0;
        start = 1'b0;
        check("done", {31'h0, done}, 32'h1);
        check("valid_off", {31'h0, instr_valid}, 32'h0);
        check("instr_off", Instruction, 32'h0);
        check("busy_off", {31'h0, busy}, 32'h0);
        @(posedge CLK);
        #1;
        check("done_pulse", {31'h0, done}, 32'h0);
        check("idle_valid", {31'h0, instr_valid}, 32'h0);
        check("cycles", vcyc, L * H + stalls);
        fin = 1'b1;
      end
    end
    $display("run prog_len=%0d len=%0d mode=%0d noise=%0d valid_cycles=%0d stalls=%0d",
             plen, L, mode, noise, vcyc, stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    // Reset and idle behaviour
    repeat (3) @(posedge CLK);
    #1;
    check_idle("reset", 1'b1);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) begin
      @(posedge CLK);
      #1;
      check_idle("idle", 1'b1);
    end

    // Basic program, then the same with a 3-cycle stall on word 1
    load_word(0, 32'h0C00A020);
    load_word(1, 32'h0E80A020);
    load_word(2, 32'h02B49820);
    load_word(3, 32'h0693B020);
    run_prog(4, 0, 1'b0, v);
    check("basic_len", v, 8);
    run_prog(4, 2, 1'b0, v);
    check("stall_total", v, 11);

    for (int i = 4; i < DEPTH; i++) load_word(i, $urandom);

    // Boundaries
    run_prog(0, 0, 1'b0, v);
    check("zero_len", v, 0);
    run_prog(31, 0, 1'b0, v);
    check("clamp_len", v, DEPTH * H);
    run_prog(31, 1, 1'b0, v);

    // Controls during ISSUE must be ignored; a clean rerun proves memory intact
    run_prog(16, 1, 1'b1, v);
    run_prog(16, 0, 1'b0, v);

    // start + load_en together in IDLE: write lands, no run
    @(negedge CLK);
    load_en = 1'b1;
    start = 1'b1;
    prog_len = 5'd4;
    load_addr = 4'd3;
    load_data = 32'hDEADBEEF;
    ref_mem[3] = 32'hDEADBEEF;
    @(negedge CLK);
    load_en = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      check_idle("no_run", 1'b0);
    end
    $display("start+load_en together addr=3 data=deadbeef");
    run_prog(4, 0, 1'b0, v);

    // Mid-run reset during word 2
    @(negedge CLK);
    start = 1'b1;
    prog_len = 5'd4;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (2 * H) @(posedge CLK);
    #1;
    check("mid_pc", {28'h0, pc}, 32'd2);
    check("mid_instr", Instruction, ref_mem[2]);
    #1 RST_N = 1'b0;
    #1;
    check_idle("rst_async", 1'b1);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check_idle("post_rst", 1'b1);
    $display("mid-run reset applied during word 2");
    run_prog(4, 0, 1'b0, v);

    // Randomized mix
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) load_word($urandom_range(0, DEPTH - 1), $urandom);
      run_prog($urandom_range(0, 31), 1, 1'($urandom_range(0, 1)), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mips_instr_issue.md
# mips_instr_issue

Program sequencer that drives the `Instruction` input of `MIPS_CPU`, replacing the hand-timed stimulus used today. Holds a small loadable instruction memory and a program counter. On `start` it issues a program of `prog_len` words, holding each word stable for `HOLD_CYCLES` clocks so the single-cycle core produces a settled `ALU_Result`. Sits between the test/boot logic and `MIPS_CPU`.

## Interface
- `DEPTH`, 16: instruction memory depth in 32-bit words (power of two).
- `ADDR_W`, 4: log2(`DEPTH`).
- `HOLD_CYCLES`, 2: clocks each instruction is presented (≥1).
- `CLK`  in  1  system clock, rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `load_en`  in  1  write `load_data` to `mem[load_addr]`.
- `load_addr`  in  `ADDR_W`  load word address.
- `load_data`  in  32  load word.
- `start`  in  1  begin issuing from address 0.
- `prog_len`  in  `ADDR_W`+1  words to issue, sampled with `start`.
- `stall`  in  1  freeze the hold counter and PC.
- `Instruction`  out  32  to `MIPS_CPU.Instruction`; 0 when not issuing.
- `instr_valid`  out  1  `Instruction` is a program word.
- `pc`  out  `ADDR_W`  address of the word on `Instruction`.
- `busy`  out  1  state is ISSUE.
- `done`  out  1  one-cycle pulse after the last word's hold ends.

## Operation
- FSM states: IDLE, ISSUE, DONE. Reset → IDLE.
- IDLE: `load_en` writes memory (accepted only in IDLE; ignored in ISSUE/DONE). `start` with `load_en` low: latch `min(prog_len, DEPTH)` as `len`; `len`=0 → DONE; otherwise → ISSUE with `pc`=0, hold counter=0. `start` with `load_en` high in the same cycle: the write happens and `start` is ignored.
- ISSUE: `Instruction`=`mem[pc]`, `instr_valid`=1. Each non-stalled cycle increments the hold counter. When it reaches `HOLD_CYCLES`-1: if `pc`=`len`-1 → DONE; otherwise `pc`+1 and counter cleared. `stall` high: counter and `pc` unchanged; `Instruction` stays stable. `start` ignored.
- DONE: `done`=1 for exactly one cycle, `Instruction`=0, `instr_valid`=0; → IDLE next cycle.
- Memory is not reset; its contents survive `RST_N`.
- `pc` wrap is impossible because `len` ≤ `DEPTH`. `prog_len` > `DEPTH` is clamped.

## Timing
- Reset values: `Instruction`=0, `instr_valid`=0, `pc`=0, `busy`=0, `done`=0; hold counter 0; `len` 0.
- All outputs are registered. `RST_N` low mid-program: outputs go to reset values immediately (asynchronously), and the FSM is in IDLE on release.
- `start` sampled at edge N → first word valid after edge N; each word valid for exactly `HOLD_CYCLES` non-stalled cycles.
- Total issue time = `len`×`HOLD_CYCLES` + stall cycles. `done` asserts the cycle after the last word drops.
- Load write visible to a `start` in the following cycle.

## Configuration
- `ISSUE_RESULT_CAPTURE_EN` defined: adds input `ALU_Result` [31:0] and outputs `result_last` [31:0] and `result_count` [`ADDR_W`:0]. On the last non-stalled hold cycle of each word, `ALU_Result` is registered into `result_last` and `result_count` is incremented. Both are cleared on reset and when a program starts.
- Macro undefined: these ports and registers do not exist.

## Test plan
- Reset: hold `RST_N`=0 → all outputs 0. Release, then idle 5 cycles → outputs unchanged.
- Basic program: load 0x0C00A020, 0x0E80A020, 0x02B49820, 0x0693B020 at 0..3; `start` with `prog_len`=4, `HOLD_CYCLES`=2 → each word valid 2 cycles in order, `pc` 0,1,2,3, `done` pulse 1 cycle after 8 valid cycles.
- Stall: assert `stall` for 3 cycles during word 1 → word 1 valid 5 cycles, and the total run is 11 cycles.
- Boundaries: `prog_len`=0 → `done` next cycle with no valid word. `prog_len`=31 with `DEPTH`=16 → 16 words issued, last `pc`=15.
- Ignored controls: `load_en` and `start` asserted during ISSUE → memory and sequence unchanged. `start`+`load_en` together in IDLE → write lands, no run.
- Mid-run reset: drop `RST_N` during word 2 → outputs 0 immediately. A fresh `start` reissues from `pc`=0 with the memory intact. With `ISSUE_RESULT_CAPTURE_EN` defined, the basic program gives `result_count`=4 and `result_last`=`ALU_Result` during word 3.
